// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg: shared types and constants for the simulation controller.
//   sim_ctrl_state_e : controller FSM states (HOLD/RUN/DRAIN/DONE)
//   DEF_*            : default parameter values for sim_ctrl
//   fail_ch_width()  : width of the fail_ch index, never less than 1 bit
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sim_ctrl_state_e;

  localparam int DEF_CNT_W        = 32;
  localparam int DEF_RST_CYCLES   = 4;
  localparam int DEF_MAX_CYCLES   = 1000;
  localparam int DEF_N_CH         = 1;
  localparam int DEF_DRAIN_CYCLES = 2;

  // A single channel still needs a 1-bit index port.
  function automatic int fail_ch_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sim_ctrl_verdict.sv
// sim_ctrl_verdict: per-channel verdict logic.
//   clk, reset : clock and synchronous active-high reset
//   run        : high while the controller is in RUN; only then is the mask updated
//   ch_passed  : per-channel pass flags (pulses accumulate in a sticky mask)
//   ch_failed  : per-channel fail flags
//   all_pass   : mask with this cycle's ch_passed ORed in is all ones
//   any_fail   : any ch_failed bit set this cycle
//   low_fail   : lowest set index of ch_failed (0 when none)
module sim_ctrl_verdict
  import sim_ctrl_pkg::*;
#(
  parameter int  N_CH  = DEF_N_CH,
  localparam int FCH_W = fail_ch_width(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [N_CH-1:0]  ch_passed,
  input  logic [N_CH-1:0]  ch_failed,
  output logic             all_pass,
  output logic             any_fail,
  output logic [FCH_W-1:0] low_fail
);

  logic [N_CH-1:0] pass_mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pass_mask_q <= '0;
    end else if (run) begin
      pass_mask_q <= pass_mask_q | ch_passed;
    end
  end

  // The final pass pulse counts in the same cycle it arrives.
  assign all_pass = &(pass_mask_q | ch_passed);
  assign any_fail = |ch_failed;

  // Scan from the top down so the lowest set index wins.
  always_comb begin
    low_fail = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_failed[i]) low_fail = FCH_W'(i);
    end
  end

endmodule

// File: rtl/sim_ctrl.sv
// sim_ctrl: simulation controller around the top-level DUT.
// Sequences dut_reset, runs a cycle counter, gathers per-channel pass/fail
// flags, enforces a watchdog and latches one sticky verdict.
// Optional feature macro: SIM_CTRL_DRAIN_EN (post-verdict drain of
// DRAIN_CYCLES cycles before the verdict becomes visible).
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   dut_reset        : reset to the DUT, high for RST_CYCLES after reset drops
//   cyc_cnt          : cycles since reset dropped; freezes on done, saturates
//   ch_passed/failed : per-channel pass/fail flags from the DUT
//   passed/failed    : sticky verdict (failed includes timeout)
//   timeout          : watchdog caused the failure
//   fail_ch          : lowest failing channel in the deciding cycle
//   done             : passed | failed
//   dbg_state        : current FSM state, for observation only
// Flags are level-sampled on every rising edge; there is no handshake, a
// one-cycle pulse is sufficient and nothing is acknowledged back.
module sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int  CNT_W        = DEF_CNT_W,
  parameter int  RST_CYCLES   = DEF_RST_CYCLES,
  parameter int  MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int  N_CH         = DEF_N_CH,
  parameter int  DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  localparam int FCH_W        = fail_ch_width(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             dut_reset,
  output logic [CNT_W-1:0] cyc_cnt,
  input  logic [N_CH-1:0]  ch_passed,
  input  logic [N_CH-1:0]  ch_failed,
  output logic             passed,
  output logic             failed,
  output logic             timeout,
  output logic [FCH_W-1:0] fail_ch,
  output logic             done,
  output sim_ctrl_state_e  dbg_state
);

  generate
    if (!((CNT_W >= 63) || (64'(MAX_CYCLES) < (64'd1 << CNT_W)))) begin : g_bad_cnt_w
      $error("sim_ctrl: CNT_W cannot hold MAX_CYCLES");
    end
    if (RST_CYCLES < 1) begin : g_bad_rst
      $error("sim_ctrl: RST_CYCLES must be at least 1");
    end
    if (MAX_CYCLES <= RST_CYCLES) begin : g_bad_max
      $error("sim_ctrl: MAX_CYCLES must exceed RST_CYCLES");
    end
    if (N_CH < 1) begin : g_bad_nch
      $error("sim_ctrl: N_CH must be at least 1");
    end
    if (DRAIN_CYCLES < 1) begin : g_bad_drain
      $error("sim_ctrl: DRAIN_CYCLES must be at least 1");
    end
  endgenerate

  sim_ctrl_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             dut_reset_q, dut_reset_d;
  logic             passed_q, passed_d;
  logic             failed_q, failed_d;
  logic             timeout_q, timeout_d;
  logic [FCH_W-1:0] fail_ch_q, fail_ch_d;

  logic             all_pass, any_fail, wd_hit;
  logic [FCH_W-1:0] low_fail;

  sim_ctrl_verdict #(.N_CH(N_CH)) u_verdict (
    .clk       (clk),
    .reset     (reset),
    .run       (state_q == RUN),
    .ch_passed (ch_passed),
    .ch_failed (ch_failed),
    .all_pass  (all_pass),
    .any_fail  (any_fail),
    .low_fail  (low_fail)
  );

  assign wd_hit = (cnt_q >= CNT_W'(MAX_CYCLES - 1));

`ifdef SIM_CTRL_DRAIN_EN
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             pend_pass_q, pend_pass_d;
  logic             pend_fail_q, pend_fail_d;
  logic             pend_to_q, pend_to_d;
  logic [FCH_W-1:0] pend_ch_q, pend_ch_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      drain_cnt_q <= '0;
      pend_pass_q <= 1'b0;
      pend_fail_q <= 1'b0;
      pend_to_q   <= 1'b0;
      pend_ch_q   <= '0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
      pend_pass_q <= pend_pass_d;
      pend_fail_q <= pend_fail_d;
      pend_to_q   <= pend_to_d;
      pend_ch_q   <= pend_ch_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    passed_d  = passed_q;
    failed_d  = failed_q;
    timeout_d = timeout_q;
    fail_ch_d = fail_ch_q;
`ifdef SIM_CTRL_DRAIN_EN
    drain_cnt_d = drain_cnt_q;
    pend_pass_d = pend_pass_q;
    pend_fail_d = pend_fail_q;
    pend_to_d   = pend_to_q;
    pend_ch_d   = pend_ch_q;
`endif
    case (state_q)
      HOLD: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        // Priority fail > pass > timeout is encoded by the guards below.
        if (any_fail || all_pass || wd_hit) begin
`ifdef SIM_CTRL_DRAIN_EN
          state_d     = DRAIN;
          drain_cnt_d = '0;
          pend_fail_d = any_fail;
          pend_pass_d = !any_fail && all_pass;
          pend_to_d   = !any_fail && !all_pass;
          pend_ch_d   = any_fail ? low_fail : '0;
`else
          state_d   = DONE;
          failed_d  = any_fail || !all_pass;
          passed_d  = !any_fail && all_pass;
          timeout_d = !any_fail && !all_pass;
          fail_ch_d = any_fail ? low_fail : '0;
`endif
        end
      end
`ifdef SIM_CTRL_DRAIN_EN
      DRAIN: begin
        // Only a pending pass can be overturned; the drain is never restarted.
        if (pend_pass_q && any_fail) begin
          pend_pass_d = 1'b0;
          pend_fail_d = 1'b1;
          pend_ch_d   = low_fail;
        end
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d   = DONE;
          passed_d  = pend_pass_d;
          failed_d  = pend_fail_d || pend_to_d;
          timeout_d = pend_to_d;
          fail_ch_d = pend_ch_d;
        end
      end
`endif
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = HOLD;
      end
    endcase
    // Registered so dut_reset drops exactly when RUN begins.
    dut_reset_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      dut_reset_q <= 1'b1;
      passed_q    <= 1'b0;
      failed_q    <= 1'b0;
      timeout_q   <= 1'b0;
      fail_ch_q   <= '0;
    end else begin
      state_q     <= state_d;
      dut_reset_q <= dut_reset_d;
      passed_q    <= passed_d;
      failed_q    <= failed_d;
      timeout_q   <= timeout_d;
      fail_ch_q   <= fail_ch_d;
      if (!(passed_q || failed_q) && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign dut_reset = dut_reset_q;
  assign cyc_cnt   = cnt_q;
  assign passed    = passed_q;
  assign failed    = failed_q;
  assign timeout   = timeout_q;
  assign fail_ch   = fail_ch_q;
  assign done      = passed_q | failed_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sim_ctrl.sv
// tb_sim_ctrl: directed plus small randomised bench for sim_ctrl with
// N_CH=2, RST_CYCLES=4, MAX_CYCLES=20. Verdict records
// {passed, failed, timeout, fail_ch, cyc_cnt} are queued when the deciding
// stimulus is driven and compared when done rises.
module tb_sim_ctrl;
  import sim_ctrl_pkg::*;

`ifdef SIM_CTRL_DRAIN_EN
  localparam int DL = 2;
`else
  localparam int DL = 0;
`endif
  localparam int W = 36;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dut_reset;
  logic [31:0] cyc_cnt;
  logic [1:0]  ch_passed = 2'b00;
  logic [1:0]  ch_failed = 2'b00;
  logic        passed, failed, timeout, done;
  logic [0:0]  fail_ch;
  sim_ctrl_state_e dbg_state;

  int checks = 0;
  int failures = 0;
  int cur = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  sim_ctrl #(
    .CNT_W(32), .RST_CYCLES(4), .MAX_CYCLES(20), .N_CH(2), .DRAIN_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dut_reset (dut_reset),
    .cyc_cnt   (cyc_cnt),
    .ch_passed (ch_passed),
    .ch_failed (ch_failed),
    .passed    (passed),
    .failed    (failed),
    .timeout   (timeout),
    .fail_ch   (fail_ch),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [W-1:0] mk(input logic p, input logic f, input logic t,
                                      input logic c, input int n);
    return {p, f, t, c, 32'(n)};
  endfunction

  function automatic logic [W-1:0] obs();
    return {passed, failed, timeout, fail_ch, cyc_cnt};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic step();
    @(negedge clk);
    cur++;
  endtask

  task automatic goto(input int k);
    while (cur < k) step();
  endtask

  // Applies reset for one edge from the current cycle; returns in cycle 0.
  task automatic do_reset();
    reset = 1'b1;
    ch_passed = 2'b00;
    ch_failed = 2'b00;
    @(negedge clk);
    chk("reset_vals", {obs(), done, dut_reset}, {mk(0, 0, 0, 0, 0), 1'b0, 1'b1});
    chk("reset_state", W'(dbg_state), W'(HOLD));
    reset = 1'b0;
    cur = 0;
  endtask

  task automatic pulse(input int k, input logic [1:0] p, input logic [1:0] f);
    goto(k);
    ch_passed = p;
    ch_failed = f;
    step();
    ch_passed = 2'b00;
    ch_failed = 2'b00;
  endtask

  // Scoreboard: wait (bounded) for done, then compare against queue head.
  task automatic wait_done(input string tag, input int budget);
    logic [W-1:0] e;
    for (int i = 0; i < budget && done !== 1'b1; i++) step();
    chk({tag, "_done"}, W'(done), W'(1'b1));
    e = exp_q.pop_front();
    chk(tag, obs(), e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0, p1, pm;
    logic [W-1:0] held;

    @(negedge clk);
    do_reset();

    // Reset sequence; HOLD ignores flags (fail at 2, partial pass at 3).
    for (int k = 0; k <= 5; k++) begin
      goto(k);
      chk($sformatf("rst_seq_c%0d", k), {W'(cyc_cnt), 1'b0},
          {W'(k), 1'b0});
      chk($sformatf("dut_reset_c%0d", k), W'(dut_reset), W'(k < 4));
      chk($sformatf("hold_nodone_c%0d", k), W'(done), W'(1'b0));
      if (k == 2) ch_failed = 2'b01;
      if (k == 3) ch_passed = 2'b10;
      if (k == 2 || k == 3) begin
        step();
        ch_failed = 2'b00;
        ch_passed = 2'b00;
      end
    end

    // Staggered pass.
    pulse(6, 2'b01, 2'b00);
    goto(8);
    chk("stagger_pending", W'(done), W'(1'b0));
    exp_q.push_back(mk(1, 0, 0, 0, 10 + DL));
    pulse(9, 2'b10, 2'b00);
    wait_done("stagger_pass", 10);

    // DONE holds and ignores inputs.
    held = mk(1, 0, 0, 0, 10 + DL);
    ch_failed = 2'b11;
    step(); step(); step();
    ch_failed = 2'b00;
    chk("done_hold", obs(), held);
    chk("done_dut_reset", W'(dut_reset), W'(1'b0));

    // Fail beats a simultaneous final pass.
    do_reset();
    exp_q.push_back(mk(0, 1, 0, 1, 8 + DL));
    pulse(7, 2'b11, 2'b10);
    wait_done("fail_priority", 10);

    // Watchdog with no flags.
    do_reset();
    exp_q.push_back(mk(0, 1, 1, 0, 20 + DL));
    wait_done("watchdog", 40);

    // Final pass in the watchdog cycle wins over timeout.
    do_reset();
    pulse(10, 2'b01, 2'b00);
    exp_q.push_back(mk(1, 0, 0, 0, 20 + DL));
    pulse(19, 2'b10, 2'b00);
    wait_done("pass_at_wd", 10);

    // Fail in the watchdog cycle reports no timeout.
    do_reset();
    exp_q.push_back(mk(0, 1, 0, 0, 20 + DL));
    pulse(19, 2'b00, 2'b01);
    wait_done("fail_at_wd", 10);

    // Mid-run reset clears outputs and the pass mask.
    do_reset();
    pulse(6, 2'b01, 2'b00);
    goto(8);
    do_reset();
    chk("midrst_cnt", W'(cyc_cnt), W'(0));
    pulse(6, 2'b10, 2'b00);
    goto(8);
    chk("midrst_mask_cleared", W'(done), W'(1'b0));
    exp_q.push_back(mk(1, 0, 0, 0, 10 + DL));
    pulse(9, 2'b01, 2'b00);
    wait_done("midrst_pass", 10);

    // Randomised pass timing.
    for (int r = 0; r < 4; r++) begin
      p0 = $urandom_range(4, 15);
      p1 = $urandom_range(4, 15);
      pm = (p0 > p1) ? p0 : p1;
      do_reset();
      for (int k = 0; k <= pm; k++) begin
        goto(k);
        ch_passed = {(k == p1), (k == p0)};
        if (k == pm) exp_q.push_back(mk(1, 0, 0, 0, pm + 1 + DL));
        step();
      end
      ch_passed = 2'b00;
      wait_done($sformatf("rand_pass_%0d", r), 10);
    end

`ifdef SIM_CTRL_DRAIN_EN
    // Fail during drain converts a pending pass.
    do_reset();
    pulse(9, 2'b11, 2'b00);
    exp_q.push_back(mk(0, 1, 0, 0, 12));
    pulse(10, 2'b00, 2'b01);
    wait_done("drain_convert", 10);

    // Conversion in the last drain cycle, channel 1.
    do_reset();
    pulse(9, 2'b11, 2'b00);
    exp_q.push_back(mk(0, 1, 0, 1, 12));
    pulse(11, 2'b00, 2'b10);
    wait_done("drain_convert_last", 10);

    // A pending fail keeps its channel.
    do_reset();
    pulse(9, 2'b01, 2'b10);
    exp_q.push_back(mk(0, 1, 0, 1, 12));
    pulse(10, 2'b00, 2'b01);
    wait_done("drain_fail_kept", 10);
`endif

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sim_ctrl.md
# sim_ctrl

Parametrised simulation controller wrapped around the top-level DUT in the Makerchip-style harness. It runs a sequenced DUT reset and a free-running cycle counter, and collects pass/fail flags from N DUT channels. It enforces a max-cycle watchdog and latches a single sticky verdict, so the simulator driver can end the run on `done`.

## Interface
- `CNT_W`, 32: cycle counter width; must hold `MAX_CYCLES` (elaboration error otherwise).
- `RST_CYCLES`, 4: cycles `dut_reset` is held after `reset` drops; ≥1.
- `MAX_CYCLES`, 1000: watchdog limit in cycles; must exceed `RST_CYCLES`.
- `N_CH`, 1: number of DUT pass/fail channels; ≥1.
- `DRAIN_CYCLES`, 2: post-verdict drain length; used only with `SIM_CTRL_DRAIN_EN`.
- `clk` in 1: the single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `dut_reset` out 1: reset driven to the DUT.
- `cyc_cnt` out `CNT_W`: cycles since `reset` dropped.
- `ch_passed` in `N_CH`: per-channel pass flags; a pulse is enough.
- `ch_failed` in `N_CH`: per-channel fail flags.
- `passed` out 1: sticky pass verdict.
- `failed` out 1: sticky fail verdict, which includes timeout.
- `timeout` out 1: sticky; set when the watchdog caused the failure.
- `fail_ch` out `$clog2(N_CH)` (minimum 1): lowest failing channel index, latched with the verdict.
- `done` out 1: `passed | failed`.

## Operation
- States: HOLD, RUN, DRAIN, DONE.
- Reset values: state HOLD; `cyc_cnt`=0; `dut_reset`=1; `passed`, `failed`, `timeout`, `done`, `fail_ch` all 0; pass mask cleared.
- `cyc_cnt` increments by 1 every non-reset cycle. It freezes once `done` asserts and saturates at all-ones.
- HOLD:
  - `dut_reset`=1 while `cyc_cnt` < `RST_CYCLES`.
  - `ch_*` inputs are ignored.
  - Moves to RUN when `cyc_cnt` == `RST_CYCLES`-1.
- RUN (`dut_reset`=0):
  - Each `ch_passed` bit sets its sticky mask bit.
  - Fail verdict: any `ch_failed` bit set.
  - Pass verdict: the mask with this cycle's `ch_passed` ORed in is all ones.
  - Timeout: `cyc_cnt` ≥ `MAX_CYCLES`-1 with no verdict this cycle.
- Verdict priority: fail > pass > timeout.
  - Simultaneous fail and final pass gives FAIL.
  - Fail and timeout in the same cycle gives FAIL with `timeout`=0.
  - Pass and timeout in the same cycle gives PASS.
- `fail_ch` = lowest set index of `ch_failed` in the deciding cycle; 0 on pass or timeout.
- DONE: outputs hold until `reset`; `dut_reset` stays 0; inputs are ignored.
- Reset mid-run from any state: the next cycle is HOLD with all outputs at their reset values.

## Timing
- The cycle after `reset` drops has `cyc_cnt`=0. `dut_reset` is high for exactly `RST_CYCLES` post-reset cycles.
- Verdict latency: input sampled at edge k, so `passed`/`failed`/`done` are high from cycle k+1. With drain, add `DRAIN_CYCLES`.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- Macro: `SIM_CTRL_DRAIN_EN`.
- Defined:
  - A verdict from RUN enters DRAIN for `DRAIN_CYCLES` cycles; `cyc_cnt` keeps counting, then the state goes to DONE.
  - A `ch_failed` bit during DRAIN converts a pending PASS into FAIL, with `fail_ch` updated. The drain is not restarted.
  - A pending FAIL or timeout is unaffected by inputs during drain.
- Undefined: the DRAIN state is absent and a verdict goes directly to DONE.

## Structure
- `sim_ctrl_pkg`:
  - state enum `sim_ctrl_state_e` (HOLD/RUN/DRAIN/DONE);
  - default parameter constants;
  - a `clog2`-with-min-1 width function for `fail_ch`.
- Sub-module `sim_ctrl_verdict`: sticky pass mask, all-passed detect, and lowest-index priority encoder on `ch_failed`. It is purely per-channel and parametrised by `N_CH`.
- `sim_ctrl` owns the FSM, counter, watchdog and output registers.

## Test plan
All scenarios use `N_CH`=2, `RST_CYCLES`=4, `MAX_CYCLES`=20, drain off unless stated.
- Reset sequence: release `reset` → `dut_reset`=1 for `cyc_cnt` 0–3 and 0 at `cyc_cnt`=4; `cyc_cnt` increments by 1 per cycle.
- Staggered pass: pulse `ch_passed`[0] at cycle 6 and `ch_passed`[1] at cycle 9 → `passed`=`done`=1 at cycle 10; `cyc_cnt` frozen at 10.
- Fail priority: at cycle 7 `ch_passed`=2'b11 and `ch_failed`=2'b10 → `failed`=1, `passed`=0, `fail_ch`=1 from cycle 8.
- Watchdog: no flags → `failed`=`timeout`=1 from cycle 20; a final pass at cycle 19 instead gives `passed`=1, `timeout`=0.
- Inputs during HOLD: `ch_failed`=2'b01 at cycle 2 → ignored; no verdict.
- Mid-run reset and drain (`SIM_CTRL_DRAIN_EN`, `DRAIN_CYCLES`=2):
  - Reset at cycle 8 → HOLD, outputs cleared, `cyc_cnt`=0 next cycle.
  - Pass decided at cycle 9 plus `ch_failed`[0] at cycle 10 → `failed`=1, `fail_ch`=0 at cycle 12.
